// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// forwarding select encodings and parameter defaults.
package hazard_ctrl_pkg;

    localparam int REG_AW_DEF      = 3;
    localparam int FLUSH_DEPTH_DEF = 2;
    localparam int DRAIN_DEPTH_DEF = 3;
    localparam int CNT_W_DEF       = 16;
    localparam int R0_ZERO_DEF     = 1;

    // Flush/drain counter only ever holds depth-1, and depths are capped at 7.
    localparam int DCNT_W = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_EX  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// One source-operand compare: picks the forwarding path and flags a
// load-use collision against the load sitting in EX.
module fwd_select
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int R0_ZERO = R0_ZERO_DEF
) (
    input  logic [REG_AW-1:0] src,
    input  logic              src_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    output fwd_sel_t          sel,
    output logic              load_hit
);

    logic src_live;
    logic ex_match;
    logic mem_match;

    // r0 is hardwired, so a read of it never needs a bypass or a stall.
    assign src_live  = src_used && !((R0_ZERO != 0) && (src == '0));
    assign ex_match  = src_live && ex_reg_write && (ex_rd == src);
    assign mem_match = src_live && mem_reg_write && (mem_rd == src);

    always_comb begin
        sel = FWD_RF;
        if (ex_match && !ex_mem_read) begin
            sel = FWD_EX;
        end else if (mem_match) begin
            sel = FWD_MEM;
        end
    end

    assign load_hit = ex_match && ex_mem_read;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall,
// redirect flush, halt drain and saturating stall/flush statistics.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEF,
    parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF,
    parameter int DRAIN_DEPTH = DRAIN_DEPTH_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int R0_ZERO     = R0_ZERO_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs2_used,
    input  logic              id_halt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic              redirect,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [DCNT_W-1:0] FLUSH_LOAD = DCNT_W'(FLUSH_DEPTH - 1);
    localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_DEPTH - 1);
    localparam state_e REDIR_ST = (FLUSH_DEPTH == 1) ? ST_RUN : ST_FLUSH;
    localparam state_e HALT_ST  = (DRAIN_DEPTH == 1) ? ST_HALTED : ST_DRAIN;

    logic [1:0][REG_AW-1:0] src;
    logic [1:0]             src_used;
    fwd_sel_t [1:0]         sel;
    logic [1:0]             load_hit;
    logic                   load_use;

    state_e            st, st_nxt;
    logic [DCNT_W-1:0] cnt, cnt_nxt;
    logic              stall_inc, flush_inc;

    // Lane 0 is operand a (always read), lane 1 is operand b.
    assign src      = {id_rs2, id_rs1};
    assign src_used = {id_rs2_used, 1'b1};

    for (genvar i = 0; i < 2; i++) begin : g_fwd
        fwd_select #(
            .REG_AW  (REG_AW),
            .R0_ZERO (R0_ZERO)
        ) u_fwd (
            .src           (src[i]),
            .src_used      (src_used[i]),
            .ex_rd         (ex_rd),
            .ex_reg_write  (ex_reg_write),
            .ex_mem_read   (ex_mem_read),
            .mem_rd        (mem_rd),
            .mem_reg_write (mem_reg_write),
            .sel           (sel[i]),
            .load_hit      (load_hit[i])
        );
    end

    assign fwd_a    = sel[0];
    assign fwd_b    = sel[1];
    assign load_use = |load_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= ST_RUN;
            cnt       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
            if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // Control outputs are gated by rst so they drop the instant reset asserts.
    always_comb begin
        st_nxt     = st;
        cnt_nxt    = cnt;
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        halted     = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (!rst) begin
            st_nxt  = ST_RUN;
            cnt_nxt = '0;
        end else if ((st != ST_HALTED) && redirect) begin
            // A redirect out of DRAIN means the halt was on the wrong path.
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            flush_inc  = (st != ST_DRAIN);
            cnt_nxt    = FLUSH_LOAD;
            st_nxt     = REDIR_ST;
        end else begin
            case (st)
                ST_RUN: begin
                    if (load_use) begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        flush_idex = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (id_halt) begin
                        stall_pc   = 1'b1;
                        flush_ifid = 1'b1;
                        cnt_nxt    = DRAIN_LOAD;
                        st_nxt     = HALT_ST;
                    end
                end
                ST_FLUSH: begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    flush_inc  = 1'b1;
                    cnt_nxt    = (cnt == '0) ? '0 : cnt - DCNT_W'(1);
                    if (cnt <= DCNT_W'(1)) st_nxt = ST_RUN;
                end
                ST_DRAIN: begin
                    stall_pc   = 1'b1;
                    flush_ifid = 1'b1;
                    cnt_nxt    = (cnt == '0) ? '0 : cnt - DCNT_W'(1);
                    if (cnt <= DCNT_W'(1)) st_nxt = ST_HALTED;
                end
                ST_HALTED: begin
                    stall_pc = 1'b1;
                    halted   = 1'b1;
                end
                default: st_nxt = ST_RUN;
            endcase
        end
    end

endmodule
